uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Buffered UART transmitter that serialises bytes onto the SoC `tx` line, 8N1 framing, LSB first. It is the transmit-side counterpart of the SoC's UART receive path. A CPU-side or bench-side writer pushes bytes into a small FIFO. The FSM drains the FIFO and sends bytes back-to-back with no idle gap between frames.

Parameters:
CLOCK_FREQ, 25000000, system clock frequency in Hz
BIT_RATE, 115200, baud rate; CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE (integer divide, must be >= 1)
FIFO_DEPTH, 16, number of byte entries; power of two, >= 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
wr_en  input  1  push wr_data into FIFO this cycle
wr_data  input  8  byte to transmit
full  output  1  FIFO holds FIFO_DEPTH entries
empty  output  1  FIFO holds 0 entries
busy  output  1  high while a frame is on the line (any state except IDLE)
tx  output  1  serial line, idle high

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high on `reset`.
- Reset values: tx=1, busy=0, empty=1, full=0; FIFO pointers and count = 0; FSM = IDLE; baud and bit counters = 0.
- Reset mid-frame: tx returns to 1 at the next edge; FIFO contents are discarded.
- FIFO write rule: a write is accepted when wr_en=1 and full=0, sampled at the same edge.
- FIFO full: a write while full=1 is dropped, even if a pop occurs in the same cycle. Count and contents are unchanged.
- full/empty: registered, derived from an occupancy count of width clog2(FIFO_DEPTH)+1. Both update on the edge after the push or pop.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop (not full): count is unchanged.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the optional feature).
- IDLE: when empty=0, pop the head byte into the shift register and enter START. tx falls at this edge.
- Start latency: a write to an empty FIFO with the FSM idle gives a tx falling edge exactly 2 clock edges after the write edge.
- Bit timing: every line bit lasts exactly CLKS_PER_BIT cycles, counted by a baud counter that runs 0..CLKS_PER_BIT-1.
- START: tx=0 for one bit time, then go to DATA.
- DATA: tx = shift[0]; shift right at the end of each bit. Leave after 8 bits, bit index 0..7.
- STOP: tx=1 for one bit time.
- End of STOP with empty=0: pop the next byte and go directly to START, so there is no idle cycle between frames.
- End of STOP with empty=1: go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- busy: 1 from the edge tx falls for the start bit until the edge the FSM re-enters IDLE.
- FIFO occupancy: writes during transmission are accepted normally. The byte in flight is no longer counted.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for one bit time, giving 8E1 framing.
- Not defined: no PARITY state and no parity logic; 8N1 framing only.

Test Plan:
- CLOCK_FREQ=8, BIT_RATE=1 (8 clk/bit), reset 3 cycles, write 0x55 once -> tx falls 2 edges after the write. Line reads 0,1,0,1,0,1,0,1,0,1 with 8 cycles per bit; busy drops after 80 cycles; empty=1.
- Write 0xA5 then 0x3C on consecutive cycles -> two frames back-to-back, second start bit immediately after first stop bit. Total 160 cycles of busy=1; data LSB-first 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- FIFO_DEPTH=4, FSM stalled by holding a frame in progress; write 6 bytes 0x01..0x06 -> full=1 after the in-flight byte plus 4 queued. Writes while full are dropped; the output byte sequence contains no dropped value.
- Assert reset in the middle of the DATA state of 0xFF with 2 bytes queued -> tx=1 on the next edge, busy=0, empty=1; no further frames appear.
- With UART_TX_PARITY_EN defined, send 0x07 -> parity bit = 1, frame of 11 bits. Send 0x55 -> parity bit = 0.
- Write at the FIFO pointer wrap point (FIFO_DEPTH+2 bytes streamed with continuous drain) -> all bytes emitted in order, none duplicated.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter (LSB first) with a byte FIFO in front.
// A writer pushes bytes into the FIFO. The FSM drains them and sends frames
// back-to-back, with no idle gap while bytes are waiting.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit (8E1 framing). Without it the framing is 8N1.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset
//   wr_en    push wr_data into the FIFO this cycle (dropped while full)
//   wr_data  byte to transmit
//   full     FIFO holds FIFO_DEPTH entries
//   empty    FIFO holds no entries
//   busy     a frame is on the line (FSM not idle)
//   tx       serial line, idle high
module uart_tx_fifo #(
    parameter int unsigned CLOCK_FREQ = 25000000,
    parameter int unsigned BIT_RATE   = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;
    logic [7:0]       rd_data;

    assign push    = wr_en && !full;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // full tracks the count at the push edge so a write can never land in a full
    // FIFO. empty trails the count by one edge: a byte written into an empty FIFO
    // is popped two edges after its write edge. empty can only read stale-low
    // just after a pop, when the FSM is in START and is not looking at it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_FULL);
            empty <= (count == '0);
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StStop   = 3'd3,
        StParity = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3
    } state_t;
`endif

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              bit_end;
`ifdef UART_TX_PARITY_EN
    logic              parity;
`endif

    assign bit_end = (baud_cnt == BAUD_LAST);

    // The FSM takes the head byte when idle, or at the end of a stop bit so the
    // next start bit follows with no gap.
    assign pop = !empty && ((state == StIdle) || ((state == StStop) && bit_end));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (!empty) begin
                        shift    <= rd_data;
`ifdef UART_TX_PARITY_EN
                        parity   <= ^rd_data;
`endif
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                        state    <= StStart;
                    end
                end

                StStart: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= StData;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                StData: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity;
                            state <= StParity;
`else
                            tx    <= 1'b1;
                            state <= StStop;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= StStop;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
`endif

                StStop: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (!empty) begin
                            shift  <= rd_data;
`ifdef UART_TX_PARITY_EN
                            parity <= ^rd_data;
`endif
                            tx     <= 1'b0;
                            state  <= StStart;
                        end else begin
                            busy  <= 1'b0;
                            state <= StIdle;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
